// File: rtl/bram_axis_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bram_axis_streamer
// Purpose  : Streams DEPTH pixels from NUM_DIR parallel BRAM banks as AXI-Stream
//            beats through a credit-limited FIFO. Optional: BRAM_STREAM_TUSER_EN.
// Revision : 1.0
// ============================================================================
module bram_axis_streamer #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_DIR       = 9,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY  = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_ready,
  output logic                               bram_en,
  output logic [ADDRESS_WIDTH-1:0]           bram_addr,
  input  logic [NUM_DIR*DATA_WIDTH-1:0]      bram_rdata,
  output logic [NUM_DIR*DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic [NUM_DIR*DATA_WIDTH/8-1:0]    m_axis_tkeep,
`ifdef BRAM_STREAM_TUSER_EN
  output logic                               m_axis_tuser,
`endif
  output logic                               busy,
  output logic                               frame_done,
  output logic                               frame_overrun
);

  localparam int TW  = NUM_DIR * DATA_WIDTH;
  localparam int KW  = TW / 8;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = CW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [READ_LATENCY-1:0]  vld_pipe_q, last_pipe_q;
  logic [TW-1:0]            fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_last_q;
  logic [PW-1:0]            rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]            count_q;
  logic                     frame_done_q, frame_overrun_q;

  logic [CW-1:0]            outstanding;
  logic [CRW-1:0]           credit_used;
  logic                     credit_ok;
  logic                     issue, issue_last;
  logic                     fifo_wr, fifo_rd, head_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight plus beats already buffered must never exceed FIFO_DEPTH.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + CW'(vld_pipe_q[i]);
    end
  end

  assign credit_used = {1'b0, outstanding} + {1'b0, count_q};
  assign credit_ok   = credit_used < CRW'(FIFO_DEPTH);
  assign issue_last  = (addr_q == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_ready) begin
          addr_d  = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDRESS_WIDTH'(1);
          if (issue_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_rd && head_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      frame_done_q    <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      frame_done_q    <= (state_q == S_DRAIN) && fifo_rd && head_last;
      frame_overrun_q <= frame_ready && (state_q != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue & issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
    end
  end

  assign fifo_wr   = vld_pipe_q[READ_LATENCY-1];
  assign fifo_rd   = m_axis_tvalid & m_axis_tready;
  assign head_last = fifo_last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_data_q[wr_ptr_q] <= bram_rdata;
      fifo_last_q[wr_ptr_q] <= last_pipe_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (fifo_rd) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

`ifdef BRAM_STREAM_TUSER_EN
  logic [READ_LATENCY-1:0] first_pipe_q;
  logic [FIFO_DEPTH-1:0]   fifo_first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      first_pipe_q <= '0;
    end else begin
      first_pipe_q[0] <= issue & (addr_q == '0);
      for (int i = 1; i < READ_LATENCY; i++) begin
        first_pipe_q[i] <= first_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_first_q[wr_ptr_q] <= first_pipe_q[READ_LATENCY-1];
    end
  end

  assign m_axis_tuser = m_axis_tvalid & fifo_first_q[rd_ptr_q];
`endif

  // Head outputs are gated by tvalid so idle outputs read as zero.
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign m_axis_tlast  = m_axis_tvalid & head_last;
  assign m_axis_tkeep  = {KW{m_axis_tvalid}};
  assign bram_en       = issue;
  assign bram_addr     = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;
  assign frame_overrun = frame_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_axis_streamer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bram_axis_streamer
// Purpose  : Directed bench for bram_axis_streamer with read latency 1 and 2.
// Revision : 1.0
// ============================================================================
module tb_bram_axis_streamer;

  localparam int DW  = 16;
  localparam int ND  = 9;
  localparam int TW  = DW * ND;
  localparam int KW  = TW / 8;
  localparam int DEP = 8;
  localparam int AW  = 4;
  localparam int FD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_ready = 1'b0;
  logic tready0 = 1'b1;

  logic          en    [2];
  logic [AW-1:0] addr  [2];
  logic [TW-1:0] rdata [2];
  logic [TW-1:0] td    [2];
  logic          tv    [2];
  logic          tl    [2];
  logic [KW-1:0] tk    [2];
  logic          bz    [2];
  logic          fdn   [2];
  logic          fov   [2];
`ifdef BRAM_STREAM_TUSER_EN
  logic          tu    [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic rst_s = 1'b1;

  int active [2], issued [2], popped [2], start_cyc [2];
  int done_exp [2], ovr_exp [2], first_seen [2];
  int first_rel [2], done_rel [2], frames [2], ovr_cnt [2];
  int iss_cyc [2][DEP];

  always #5 clk = ~clk;

  bram_axis_streamer #(
    .DATA_WIDTH(DW), .NUM_DIR(ND), .DEPTH(DEP), .ADDRESS_WIDTH(AW),
    .READ_LATENCY(1), .FIFO_DEPTH(FD)
  ) u_dut0 (
    .clk(clk), .rst(rst), .frame_ready(frame_ready),
    .bram_en(en[0]), .bram_addr(addr[0]), .bram_rdata(rdata[0]),
    .m_axis_tdata(td[0]), .m_axis_tvalid(tv[0]), .m_axis_tready(tready0),
    .m_axis_tlast(tl[0]), .m_axis_tkeep(tk[0]),
`ifdef BRAM_STREAM_TUSER_EN
    .m_axis_tuser(tu[0]),
`endif
    .busy(bz[0]), .frame_done(fdn[0]), .frame_overrun(fov[0])
  );

  bram_axis_streamer #(
    .DATA_WIDTH(DW), .NUM_DIR(ND), .DEPTH(DEP), .ADDRESS_WIDTH(AW),
    .READ_LATENCY(2), .FIFO_DEPTH(FD)
  ) u_dut1 (
    .clk(clk), .rst(rst), .frame_ready(frame_ready),
    .bram_en(en[1]), .bram_addr(addr[1]), .bram_rdata(rdata[1]),
    .m_axis_tdata(td[1]), .m_axis_tvalid(tv[1]), .m_axis_tready(1'b1),
    .m_axis_tlast(tl[1]), .m_axis_tkeep(tk[1]),
`ifdef BRAM_STREAM_TUSER_EN
    .m_axis_tuser(tu[1]),
`endif
    .busy(bz[1]), .frame_done(fdn[1]), .frame_overrun(fov[1])
  );

  // Bank k at address a holds a*16+k.
  function automatic logic [TW-1:0] pix(input int a);
    logic [TW-1:0] v;
    v = '0;
    for (int k = 0; k < ND; k++) v[k*DW +: DW] = DW'(a * 16 + k);
    return v;
  endfunction

  logic [TW-1:0] s1 [2];
  logic [TW-1:0] s2;
  always @(posedge clk) begin
    if (en[0]) s1[0] <= pix(int'(addr[0]));
    if (en[1]) s1[1] <= pix(int'(addr[1]));
    s2 <= s1[1];
  end
  assign rdata[0] = s1[0];
  assign rdata[1] = s2;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  task automatic chk(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic model_cycle(input int d);
    int  lat, avail;
    bit  exp_en, exp_tv, rdy, was_active;
    lat    = d + 1;
    rdy    = (d == 0) ? tready0 : 1'b1;
    exp_en = 1'b0;
    exp_tv = 1'b0;
    if (rst_s) begin
      chk("rst_tvalid", d, tv[d], 0);
      chk("rst_tkeep", d, tk[d], 0);
      chk("rst_tdata", d, td[d], 0);
      chk("rst_tlast", d, tl[d], 0);
      chk("rst_busy", d, bz[d], 0);
      chk("rst_bram_en", d, en[d], 0);
      chk("rst_bram_addr", d, addr[d], 0);
      chk("rst_frame_done", d, fdn[d], 0);
      chk("rst_overrun", d, fov[d], 0);
`ifdef BRAM_STREAM_TUSER_EN
      chk("rst_tuser", d, tu[d], 0);
`endif
      active[d] = 0;
      issued[d] = 0;
      popped[d] = 0;
    end else begin
      exp_en = (active[d] != 0) && (issued[d] < DEP) && (issued[d] - popped[d] < FD);
      chk("bram_en", d, en[d], exp_en);
      if (exp_en) chk("bram_addr", d, addr[d], issued[d]);
      avail = 0;
      for (int a = 0; a < issued[d]; a++) if (iss_cyc[d][a] + lat + 1 <= cyc) avail++;
      avail  = avail - popped[d];
      exp_tv = (avail > 0);
      chk("tvalid", d, tv[d], exp_tv);
      if (exp_tv) begin
        chk("tdata", d, td[d], pix(popped[d]));
        chk("tlast", d, tl[d], popped[d] == DEP - 1);
        chk("tkeep", d, tk[d], {KW{1'b1}});
`ifdef BRAM_STREAM_TUSER_EN
        chk("tuser", d, tu[d], popped[d] == 0);
`endif
      end else begin
        chk("idle_tkeep", d, tk[d], 0);
        chk("idle_tlast", d, tl[d], 0);
        chk("idle_tdata", d, td[d], 0);
      end
      chk("busy", d, bz[d], active[d] != 0);
      chk("frame_done", d, fdn[d], done_exp[d] != 0);
      chk("frame_overrun", d, fov[d], ovr_exp[d] != 0);
      if (fdn[d]) done_rel[d] = cyc - start_cyc[d];
      if (fov[d]) ovr_cnt[d]++;
      if (tv[d] && first_seen[d] == 0) begin
        first_rel[d]  = cyc - start_cyc[d];
        first_seen[d] = 1;
      end
    end
    done_exp[d] = 0;
    ovr_exp[d]  = 0;
    if (!rst) begin
      was_active = (active[d] != 0);
      ovr_exp[d] = int'(frame_ready && was_active);
      if (exp_en) begin
        iss_cyc[d][issued[d]] = cyc;
        issued[d]++;
      end
      if (exp_tv && rdy) begin
        if (popped[d] == DEP - 1) begin
          done_exp[d] = 1;
          active[d]   = 0;
          frames[d]++;
        end
        popped[d]++;
      end
      if (frame_ready && !was_active) begin
        active[d]     = 1;
        issued[d]     = 0;
        popped[d]     = 0;
        start_cyc[d]  = cyc;
        first_seen[d] = 0;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      active[d] = 0; issued[d] = 0; popped[d] = 0; start_cyc[d] = 0;
      done_exp[d] = 0; ovr_exp[d] = 0; first_seen[d] = 0;
      first_rel[d] = -1; done_rel[d] = -1; frames[d] = 0; ovr_cnt[d] = 0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) model_cycle(d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle);
    int n = 0;
    while ((bz[0] || bz[1]) && n < 300) begin
      tready0 = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      step();
      n++;
    end
    tready0 = 1'b1;
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout: busy still %0d/%0d expected 0", bz[0], bz[1]);
    end
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (popped[0] < target && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_beats timeout: got %0d beats expected %0d", popped[0], target);
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Full-rate frame on both latencies
    pulse_frame();
    wait_idle(1'b0);
    step();
    chk("lit_first_tvalid", 0, first_rel[0], 3);
    chk("lit_frame_done", 0, done_rel[0], 11);
    chk("lit_first_tvalid", 1, first_rel[1], 4);
    chk("lit_frame_done", 1, done_rel[1], 12);
    chk("lit_frames", 0, frames[0], 1);

    // Back-pressure 1,0,0,1 on the latency-1 instance
    pulse_frame();
    wait_idle(1'b1);
    step();
    chk("lit_frames_bp", 0, frames[0], 2);
    chk("lit_frames_bp", 1, frames[1], 2);

    // frame_ready mid-frame
    pulse_frame();
    wait_beats(3);
    pulse_frame();
    wait_idle(1'b0);
    repeat (5) step();
    chk("lit_overrun_cnt", 0, ovr_cnt[0], 1);
    chk("lit_overrun_cnt", 1, ovr_cnt[1], 1);
    chk("lit_frames_ovr", 0, frames[0], 3);

    // frame_ready on the final handshake, then a back-to-back frame
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    begin
      int n = 0;
      while (!(tv[0] && tl[0]) && n < 100) begin
        step();
        n++;
      end
    end
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    wait_idle(1'b0);
    pulse_frame();
    wait_idle(1'b0);
    step();
    chk("lit_overrun_cnt2", 0, ovr_cnt[0], 2);
    chk("lit_frames_b2b", 0, frames[0], 5);
    chk("lit_frames_b2b", 1, frames[1], 5);

    // Reset mid-frame, then a clean frame
    pulse_frame();
    wait_beats(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    pulse_frame();
    wait_idle(1'b0);
    repeat (3) step();
    chk("lit_frames_rst", 0, frames[0], 6);
    chk("lit_frames_rst", 1, frames[1], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
